mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the multicycle processor's unified instruction/data bus: serves fetches, loads and stores.
- The processor drives Adr, MemWrite and WriteData. This block returns ReadData and completes each access with a Ready pulse after a programmable latency.
- It sits at the top level beside the processor core and replaces the ideal zero-wait-state memory.
- Storage is word-organised; every access is a full 32-bit word.

Parameters:
- DEPTH, 64, number of 32-bit words stored (power of 2, >=4).
- ADDR_BASE, 32'h0000_0000, byte address mapped to word 0.
- RD_LATENCY, 2, cycles from request acceptance to Ready for a read (>=1).
- WR_LATENCY, 1, cycles from request acceptance to Ready for a write (>=1).

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- MemReq  in  1  access request strobe; held by the initiator until Ready
- MemWrite  in  1  1 = write, 0 = read; sampled at acceptance
- Adr  in  32  byte address; sampled at acceptance
- WriteData  in  32  store data; sampled at acceptance
- ReadData  out  32  read result; valid in the Ready cycle and held until the next read completes
- Ready  out  1  one-cycle completion pulse
- Err  out  1  asserted together with Ready when the access was faulted

Behaviour:
- Reset: sampled only on a clk edge while reset=0.
  - State goes to IDLE; Ready=0, Err=0, ReadData=0; the latency counter clears.
  - Storage contents are not cleared.
  - A reset during BUSY aborts the access: no write commit and no Ready pulse.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: with MemReq=1, latch Adr, MemWrite and WriteData, load the counter with (latency-1), and go to BUSY. The latency is RD_LATENCY or WR_LATENCY according to MemWrite.
  - BUSY: decrement the counter each cycle. When the counter is 0, perform the access and go to DONE.
  - DONE: Ready=1 for exactly this cycle. Err is valid this cycle. Next state is always IDLE.
  - Ready is therefore high in the cycle (latency+1) after the acceptance cycle.
- Request rules:
  - A new request is accepted only in IDLE.
  - MemReq, Adr, MemWrite and WriteData in BUSY and DONE are ignored; the latched values govern the access.
  - MemReq still high in the cycle after DONE is treated as a new request, because the initiator has deasserted after Ready. Back-to-back accesses therefore cost (latency+2) cycles each.
- Address decode:
  - offset = Adr_latched - ADDR_BASE, computed in 32 bits with wrap-around.
  - index = offset[log2(DEPTH)+1:2].
  - Fault if offset[1:0] != 0 (misaligned) or offset >= 4*DEPTH (out of range, including wrapped negatives).
- Read, no fault: ReadData <= mem[index] on the edge entering DONE.
- Read, fault: ReadData <= 32'h0000_0000 and Err=1.
- Write, no fault: mem[index] <= WriteData_latched on the edge entering DONE. ReadData is unchanged.
- Write, fault: the write is dropped and Err=1.
- Read-after-write to the same word returns the newly written data; there is no forwarding hazard because accesses are serialised.
- Err is 0 outside the DONE cycle.

Optional Feature:
- Macro: MEM_ACCESS_CNT_EN.
- Defined:
  - Adds outputs RdCount[31:0] and WrCount[31:0].
  - Each counts completed accesses, including faulted ones, incrementing on the edge entering DONE.
  - Both counters clear on reset and wrap from 32'hFFFF_FFFF to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package mem_pkg holds:
  - the state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10);
  - the fault read value 32'h0000_0000;
  - a function computing log2(DEPTH).
- Sub-module mem_array: a single-port synchronous word RAM with DEPTH words, write enable, index and data in/out, no reset. It is instantiated once. The FSM, decode and counters stay in mem_responder.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, then release with MemReq=0 -> Ready=0, Err=0, ReadData=0 for 10 cycles.
- Write/read round trip with defaults:
  - Write 32'hCAFE_F00D to Adr=32'h10 -> Ready one cycle, 2 cycles after acceptance.
  - Read Adr=32'h10 -> Ready 3 cycles after acceptance with ReadData=32'hCAFE_F00D, Err=0.
- Misaligned and out-of-range faults:
  - Read Adr=32'h13 -> Ready and Err=1, ReadData=0.
  - Write Adr=32'h100 (DEPTH=64) -> Err=1; a later read of Adr=32'h0 returns its prior contents.
- Request held and back-to-back: hold MemReq=1 for three reads at 0x0, 0x4, 0x8 -> Ready pulses spaced exactly RD_LATENCY+2=4 cycles apart, each with correct data. Adr changes during BUSY are ignored.
- Reset mid-access:
  - Accept a write of 32'h1234_5678 to 0x20 and assert reset in the BUSY cycle -> no Ready pulse, mem[8] unchanged.
  - After release, a read of 0x20 returns the old value.
- MEM_ACCESS_CNT_EN defined: 5 reads and 3 writes (one faulted) -> RdCount=5, WrCount=3; reset -> both 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for mem_responder: FSM state encoding, fault read value,
// and a log2 helper used to size index and latency counter widths.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mem_state_t;

    localparam logic [31:0] FAULT_RDATA = 32'h0000_0000;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int mem_log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Processor-to-memory bus: request (Adr/MemWrite/WriteData/MemReq) and
// completion (ReadData/Ready/Err). The processor is master, memory is slave.
interface mem_responder_if;
    logic        MemReq;
    logic        MemWrite;
    logic [31:0] Adr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Ready;
    logic        Err;

    modport master (
        output MemReq, MemWrite, Adr, WriteData,
        input  ReadData, Ready, Err
    );

    modport slave (
        input  MemReq, MemWrite, Adr, WriteData,
        output ReadData, Ready, Err
    );
endinterface

// File: rtl/mem_array.sv
// Single-port synchronous word RAM, no reset. The read register only updates
// on i_re so its value persists between reads.
module mem_array #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_idx,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_idx] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_idx];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder with programmable read/write latency (IDLE/BUSY/DONE).
// Define MEM_ACCESS_CNT_EN to add RdCount/WrCount completed-access counters.
module mem_responder
    import mem_pkg::*;
#(
    parameter int          DEPTH      = 64,
    parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
    parameter int          RD_LATENCY = 2,
    parameter int          WR_LATENCY = 1
) (
    input  logic           clk,
    input  logic           reset,
`ifdef MEM_ACCESS_CNT_EN
    output logic [31:0]    RdCount,
    output logic [31:0]    WrCount,
`endif
    mem_responder_if.slave bus
);

    localparam int AW      = mem_log2(DEPTH);
    localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int CNT_W   = mem_log2(MAX_LAT) + 1;

    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LATENCY - 1);
    localparam logic [31:0]      SPAN    = 32'(4 * DEPTH);

    mem_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_write;
    logic [31:0]      r_adr;
    logic [31:0]      r_wdata;
    logic             r_ready;
    logic             r_err;
    logic             r_src_ram;

    logic [31:0]      w_offset;
    logic             w_fault;
    logic [AW-1:0]    w_idx;
    logic             w_fire;
    logic             w_we;
    logic             w_re;
    logic [31:0]      w_ram_rdata;

    // Unsigned wrap makes addresses below ADDR_BASE land far out of range.
    assign w_offset = r_adr - ADDR_BASE;
    assign w_fault  = (w_offset[1:0] != 2'b00) || (w_offset >= SPAN);
    assign w_idx    = w_offset[AW+1:2];

    assign w_fire = (r_state == BUSY) && (r_cnt == '0);
    // Gated by reset so an access aborted in BUSY never reaches the RAM.
    assign w_we   = w_fire &&  r_write && !w_fault && reset;
    assign w_re   = w_fire && !r_write && !w_fault && reset;

    mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_idx   (w_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_write   <= 1'b0;
            r_adr     <= '0;
            r_wdata   <= '0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_src_ram <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                    if (bus.MemReq) begin
                        r_adr   <= bus.Adr;
                        r_write <= bus.MemWrite;
                        r_wdata <= bus.WriteData;
                        r_cnt   <= bus.MemWrite ? WR_LOAD : RD_LOAD;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= DONE;
                        r_ready <= 1'b1;
                        r_err   <= w_fault;
                        // ReadData follows the RAM register after a good read, else reads 0.
                        if (!r_write) r_src_ram <= !w_fault;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ReadData = r_src_ram ? w_ram_rdata : FAULT_RDATA;
    assign bus.Ready    = r_ready;
    assign bus.Err      = r_err;

`ifdef MEM_ACCESS_CNT_EN
    logic [31:0] r_rd_cnt;
    logic [31:0] r_wr_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else if (w_fire) begin
            if (r_write) r_wr_cnt <= r_wr_cnt + 32'd1;
            else         r_rd_cnt <= r_rd_cnt + 32'd1;
        end
    end

    assign RdCount = r_rd_cnt;
    assign WrCount = r_wr_cnt;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (default parameters).
// Counter checks are compiled in when MEM_ACCESS_CNT_EN is defined.
module tb_mem_responder;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    mem_responder_if bus ();

`ifdef MEM_ACCESS_CNT_EN
    logic [31:0] RdCount;
    logic [31:0] WrCount;
`endif

    mem_responder dut (
        .clk     (clk),
        .reset   (reset),
`ifdef MEM_ACCESS_CNT_EN
        .RdCount (RdCount),
        .WrCount (WrCount),
`endif
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one access and wait for Ready; k = cycles after acceptance (0 = timeout).
    task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          output int k, output logic [31:0] rd, output logic er);
        k  = 0;
        rd = 32'hxxxx_xxxx;
        er = 1'bx;
        @(posedge clk); #1;
        bus.MemReq = 1'b1; bus.MemWrite = wr; bus.Adr = a; bus.WriteData = d;
        @(posedge clk); #1;
        bus.MemReq = 1'b0; bus.MemWrite = 1'b0; bus.Adr = 32'hFFFF_FFF0; bus.WriteData = 32'h0BAD_0BAD;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (bus.Ready === 1'b1) begin
                k  = c;
                rd = bus.ReadData;
                er = bus.Err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.MemReq = 1'b0; bus.MemWrite = 1'b0; bus.Adr = '0; bus.WriteData = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if ({bus.Ready, bus.Err, bus.ReadData} !== 34'h0) begin
                miscompares++;
                $display("FAIL reset_idle cyc=%0d got Ready=%b Err=%b ReadData=%h want 0/0/0",
                         i, bus.Ready, bus.Err, bus.ReadData);
            end
        end
    endtask

    task automatic test_write_read();
        int k; logic [31:0] rd; logic er;
        access(1'b1, 32'h10, 32'hCAFE_F00D, k, rd, er);
        vectors++;
        if (k !== 2 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_latency got k=%0d err=%b want k=2 err=0", k, er);
        end
        @(negedge clk);
        vectors++;
        if (bus.Ready !== 1'b0 || bus.Err !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_pulse_width got Ready=%b Err=%b want 0/0", bus.Ready, bus.Err);
        end
        access(1'b0, 32'h10, 32'h0, k, rd, er);
        vectors++;
        if (k !== 3 || rd !== 32'hCAFE_F00D || er !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_roundtrip got k=%0d data=%h err=%b want k=3 data=cafef00d err=0", k, rd, er);
        end
        @(negedge clk);
        vectors++;
        if (bus.Ready !== 1'b0 || bus.ReadData !== 32'hCAFE_F00D) begin
            miscompares++;
            $display("FAIL rd_hold got Ready=%b ReadData=%h want 0/cafef00d", bus.Ready, bus.ReadData);
        end
        access(1'b1, 32'h14, 32'h0000_0001, k, rd, er);
        vectors++;
        if (k !== 2 || bus.ReadData !== 32'hCAFE_F00D) begin
            miscompares++;
            $display("FAIL wr_keeps_rdata got k=%0d ReadData=%h want k=2 cafef00d", k, bus.ReadData);
        end
    endtask

    task automatic test_faults();
        int k; logic [31:0] rd; logic er;
        access(1'b1, 32'h0, 32'hA5A5_0001, k, rd, er);
        access(1'b0, 32'h13, 32'h0, k, rd, er);
        vectors++;
        if (k !== 3 || er !== 1'b1 || rd !== 32'h0) begin
            miscompares++;
            $display("FAIL misaligned_rd got k=%0d err=%b data=%h want 3/1/0", k, er, rd);
        end
        @(negedge clk);
        vectors++;
        if (bus.Err !== 1'b0 || bus.ReadData !== 32'h0) begin
            miscompares++;
            $display("FAIL err_clears got Err=%b ReadData=%h want 0/0", bus.Err, bus.ReadData);
        end
        access(1'b1, 32'h100, 32'hDEAD_BEEF, k, rd, er);
        vectors++;
        if (k !== 2 || er !== 1'b1) begin
            miscompares++;
            $display("FAIL oor_wr got k=%0d err=%b want 2/1", k, er);
        end
        access(1'b0, 32'h0, 32'h0, k, rd, er);
        vectors++;
        if (rd !== 32'hA5A5_0001 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL oor_wr_dropped got data=%h err=%b want a5a50001/0", rd, er);
        end
        access(1'b1, 32'hFC, 32'h0BAD_F00D, k, rd, er);
        vectors++;
        if (er !== 1'b0) begin
            miscompares++;
            $display("FAIL last_word_wr got err=%b want 0", er);
        end
        access(1'b0, 32'hFC, 32'h0, k, rd, er);
        vectors++;
        if (rd !== 32'h0BAD_F00D || er !== 1'b0) begin
            miscompares++;
            $display("FAIL last_word_rd got data=%h err=%b want 0badf00d/0", rd, er);
        end
        access(1'b0, 32'hFFFF_FFFC, 32'h0, k, rd, er);
        vectors++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            miscompares++;
            $display("FAIL wrap_neg_rd got err=%b data=%h want 1/0", er, rd);
        end
        access(1'b0, 32'h3, 32'h0, k, rd, er);
        vectors++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            miscompares++;
            $display("FAIL misaligned_low got err=%b data=%h want 1/0", er, rd);
        end
    endtask

    task automatic test_back_to_back();
        int k; logic [31:0] rd; logic er;
        logic [31:0] adrs [3];
        logic [31:0] exp  [3];
        int          rcyc [3];
        logic [31:0] rdat [3];
        int          n;
        bit          prev_ready;
        adrs[0] = 32'h0; adrs[1] = 32'h4; adrs[2] = 32'h8;
        exp[0]  = 32'h1000_0000; exp[1] = 32'h2000_0004; exp[2] = 32'h3000_0008;
        for (int i = 0; i < 3; i++) access(1'b1, adrs[i], exp[i], k, rd, er);
        n = 0;
        prev_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin rcyc[i] = -1; rdat[i] = '0; end
        @(posedge clk); #1;
        bus.MemReq = 1'b1; bus.MemWrite = 1'b0; bus.Adr = adrs[0];
        for (int c = 0; c < 60 && n < 3; c++) begin
            @(negedge clk);
            if (bus.Ready === 1'b1) begin
                rcyc[n] = c;
                rdat[n] = bus.ReadData;
                n++;
                bus.MemWrite = 1'b0;
                if (n < 3) bus.Adr = adrs[n];
                else       bus.MemReq = 1'b0;
                prev_ready = 1'b1;
            end else begin
                // Garbage on the bus while BUSY must not affect the latched access.
                if (!prev_ready && c > 0) begin
                    bus.Adr = 32'h40; bus.MemWrite = 1'b1; bus.WriteData = 32'hBADB_AD00;
                end
                prev_ready = 1'b0;
            end
        end
        bus.MemReq = 1'b0; bus.MemWrite = 1'b0;
        vectors++;
        if (rcyc[0] !== 3) begin
            miscompares++;
            $display("FAIL b2b_first got cycle=%0d want 3", rcyc[0]);
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (rdat[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL b2b_data%0d got %h want %h", i, rdat[i], exp[i]);
            end
        end
        for (int i = 1; i < 3; i++) begin
            vectors++;
            if (rcyc[i] - rcyc[i-1] !== 4) begin
                miscompares++;
                $display("FAIL b2b_spacing%0d got %0d want 4", i, rcyc[i] - rcyc[i-1]);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        int k; logic [31:0] rd; logic er;
        int pulses;
        access(1'b1, 32'h20, 32'h5555_AAAA, k, rd, er);
        access(1'b0, 32'h8, 32'h0, k, rd, er);
        @(posedge clk); #1;
        bus.MemReq = 1'b1; bus.MemWrite = 1'b1; bus.Adr = 32'h20; bus.WriteData = 32'h1234_5678;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.MemReq = 1'b0; bus.MemWrite = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        pulses = 0;
        @(negedge clk);
        vectors++;
        if (bus.ReadData !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_clears_rdata got %h want 0", bus.ReadData);
        end
        for (int i = 0; i < 6; i++) begin
            if (bus.Ready === 1'b1) pulses++;
            @(negedge clk);
        end
        vectors++;
        if (pulses !== 0) begin
            miscompares++;
            $display("FAIL abort_no_ready got %0d pulses want 0", pulses);
        end
        access(1'b0, 32'h20, 32'h0, k, rd, er);
        vectors++;
        if (k !== 3 || rd !== 32'h5555_AAAA || er !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_no_commit got k=%0d data=%h err=%b want 3/5555aaaa/0", k, rd, er);
        end
    endtask

`ifdef MEM_ACCESS_CNT_EN
    task automatic test_counters();
        int k; logic [31:0] rd; logic er;
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (RdCount !== 32'd0 || WrCount !== 32'd0) begin
            miscompares++;
            $display("FAIL cnt_after_reset got rd=%0d wr=%0d want 0/0", RdCount, WrCount);
        end
        access(1'b0, 32'h0,  32'h0, k, rd, er);
        access(1'b0, 32'h4,  32'h0, k, rd, er);
        access(1'b1, 32'h30, 32'h1, k, rd, er);
        access(1'b0, 32'h13, 32'h0, k, rd, er);
        access(1'b1, 32'h34, 32'h2, k, rd, er);
        access(1'b0, 32'h30, 32'h0, k, rd, er);
        access(1'b1, 32'h101, 32'h3, k, rd, er);
        access(1'b0, 32'h34, 32'h0, k, rd, er);
        @(negedge clk);
        vectors++;
        if (RdCount !== 32'd5 || WrCount !== 32'd3) begin
            miscompares++;
            $display("FAIL cnt_totals got rd=%0d wr=%0d want 5/3", RdCount, WrCount);
        end
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (RdCount !== 32'd0 || WrCount !== 32'd0) begin
            miscompares++;
            $display("FAIL cnt_reset_clear got rd=%0d wr=%0d want 0/0", RdCount, WrCount);
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_write_read();
        test_faults();
        test_back_to_back();
        test_reset_mid_access();
`ifdef MEM_ACCESS_CNT_EN
        test_counters();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
